// File: rtl/tlk2711_tx_sched_if.sv
// Word stream from a user source into the TLK2711 transmit scheduler.
// The source drives valid/data/last; the scheduler drives ready.
interface tlk2711_tx_sched_if;
    logic        valid;
    logic [15:0] data;
    logic        last;
    logic        ready;

    modport master (output valid, output data, output last, input ready);
    modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/tlk2711_tx_sched.sv
// TLK2711 lane transmit scheduler: power-up/lock/sync sequencing, then round-robin framing of
// two word streams as SOF / header / payload / EOF with K-character flags.
module tlk2711_tx_sched #(
    parameter int unsigned LOCK_CYCLES = 1024,
    parameter int unsigned SYNC_WORDS  = 64,
    parameter int unsigned IFG_WORDS   = 4,
    parameter int unsigned MAX_WORDS   = 1024
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [2:0]                 i_mode,
    input  logic                       i_stop,
    output logic                       o_stop_ack,
    tlk2711_tx_sched_if.slave          s0,
    tlk2711_tx_sched_if.slave          s1,
    output logic [15:0]                o_txd,
    output logic                       o_tkmsb,
    output logic                       o_tklsb,
    output logic                       o_enable,
    output logic                       o_lckrefn,
    output logic                       o_loopen,
    output logic                       o_prbsen,
    output logic                       o_testen,
    output logic                       o_link_up,
    output logic                       o_trunc
);
    localparam logic [15:0] WordIdle = 16'hC5BC;
    localparam logic [15:0] WordSof  = 16'h50FB;
    localparam logic [15:0] WordEof  = 16'h50FD;

    typedef enum logic [3:0] {
        StPwr, StLock, StSync, StIdle, StSof, StHdr, StData, StEof, StGap, StDrain, StStopped
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] cnt_q, cnt_d;
    logic        ch_q, ch_d;
    logic        rr_q, rr_d;
    logic        pend_q, pend_d;
    logic [7:0]  seq0_q, seq0_d, seq1_q, seq1_d;
    logic [15:0] txd_q, txd_d;
    logic        tkmsb_q, tkmsb_d, tklsb_q, tklsb_d;
    logic        enable_q, enable_d, lckrefn_q, lckrefn_d;
    logic        loopen_q, loopen_d, prbsen_q, prbsen_d;
    logic        link_up_q, link_up_d, stop_ack_q, stop_ack_d, trunc_q, trunc_d;

    logic        busy, hs, hs_last;
    logic [15:0] hs_data;
    logic [7:0]  cur_seq;

    assign busy     = (state_q == StData) || (state_q == StDrain);
    assign s0.ready = busy && !ch_q;
    assign s1.ready = busy && ch_q;
    assign hs       = busy && (ch_q ? s1.valid : s0.valid);
    assign hs_data  = ch_q ? s1.data : s0.data;
    assign hs_last  = ch_q ? s1.last : s0.last;
    assign cur_seq  = ch_q ? seq1_q : seq0_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        ch_d      = ch_q;
        rr_d      = rr_q;
        pend_d    = pend_q;
        seq0_d    = seq0_q;
        seq1_d    = seq1_q;
        txd_d     = WordIdle;
        tkmsb_d   = 1'b0;
        tklsb_d   = 1'b1;
        enable_d  = enable_q;
        lckrefn_d = lckrefn_q;
        loopen_d  = loopen_q;
        prbsen_d  = prbsen_q;
        link_up_d = link_up_q;
        trunc_d   = 1'b0;
        unique case (state_q)
            StPwr: begin
                enable_d = 1'b1;
                state_d  = StLock;
            end
            StLock: begin
                lckrefn_d = 1'b1;
                if (cnt_q == LOCK_CYCLES - 1) begin
                    cnt_d   = '0;
                    state_d = StSync;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StSync: begin
                if (cnt_q == SYNC_WORDS - 1) begin
                    cnt_d   = '0;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StIdle: begin
                link_up_d = 1'b1;
                loopen_d  = (i_mode == 3'd1);
                prbsen_d  = (i_mode == 3'd2);
                if (i_stop) begin
                    state_d = StStopped;
                end else if ((i_mode != 3'd2) && (s0.valid || s1.valid)) begin
                    // Contention goes to the round-robin pointer; a lone requester always wins.
                    ch_d    = (s0.valid && s1.valid) ? rr_q : s1.valid;
                    state_d = StSof;
                end
            end
            StSof: begin
                txd_d   = WordSof;
                state_d = StHdr;
            end
            StHdr: begin
                txd_d   = {cur_seq, 7'b0, ch_q};
                tklsb_d = 1'b0;
                cnt_d   = '0;
                state_d = StData;
            end
            StData: begin
                if (hs) begin
                    txd_d   = hs_data;
                    tklsb_d = 1'b0;
                    cnt_d   = cnt_q + 32'd1;
                    if (hs_last || (cnt_q == MAX_WORDS - 1)) begin
                        pend_d  = !hs_last;
                        state_d = StEof;
                    end
                end
            end
            StEof: begin
                txd_d   = WordEof;
                trunc_d = pend_q;
                if (ch_q) seq1_d = seq1_q + 8'd1;
                else      seq0_d = seq0_q + 8'd1;
                rr_d    = ~ch_q;
                cnt_d   = '0;
                state_d = StGap;
            end
            StGap: begin
                if (cnt_q == IFG_WORDS - 1) begin
                    cnt_d   = '0;
                    state_d = pend_q ? StDrain : StIdle;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            StDrain: begin
                // Discard the rest of a truncated frame; nothing reaches the wire.
                if (hs && hs_last) begin
                    pend_d  = 1'b0;
                    state_d = StIdle;
                end
            end
            StStopped: begin
                loopen_d = (i_mode == 3'd1);
                prbsen_d = (i_mode == 3'd2);
                if (!i_stop) state_d = StIdle;
            end
            default: state_d = StPwr;
        endcase
        stop_ack_d = (state_d == StStopped);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StPwr;
            cnt_q      <= '0;
            ch_q       <= 1'b0;
            rr_q       <= 1'b0;
            pend_q     <= 1'b0;
            seq0_q     <= '0;
            seq1_q     <= '0;
            txd_q      <= WordIdle;
            tkmsb_q    <= 1'b0;
            tklsb_q    <= 1'b1;
            enable_q   <= 1'b0;
            lckrefn_q  <= 1'b0;
            loopen_q   <= 1'b0;
            prbsen_q   <= 1'b0;
            link_up_q  <= 1'b0;
            stop_ack_q <= 1'b0;
            trunc_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            rr_q       <= rr_d;
            pend_q     <= pend_d;
            seq0_q     <= seq0_d;
            seq1_q     <= seq1_d;
            txd_q      <= txd_d;
            tkmsb_q    <= tkmsb_d;
            tklsb_q    <= tklsb_d;
            enable_q   <= enable_d;
            lckrefn_q  <= lckrefn_d;
            loopen_q   <= loopen_d;
            prbsen_q   <= prbsen_d;
            link_up_q  <= link_up_d;
            stop_ack_q <= stop_ack_d;
            trunc_q    <= trunc_d;
        end
    end

    assign o_txd      = txd_q;
    assign o_tkmsb    = tkmsb_q;
    assign o_tklsb    = tklsb_q;
    assign o_enable   = enable_q;
    assign o_lckrefn  = lckrefn_q;
    assign o_loopen   = loopen_q;
    assign o_prbsen   = prbsen_q;
    assign o_testen   = 1'b0;
    assign o_link_up  = link_up_q;
    assign o_stop_ack = stop_ack_q;
    assign o_trunc    = trunc_q;
endmodule

// File: tb/tb_tlk2711_tx_sched.sv
// Directed bench for tlk2711_tx_sched: every wire word is logged with its flags and compared
// against hand-built expected sequences.
module tb_tlk2711_tx_sched;
    localparam int unsigned L = 8;
    localparam int unsigned S = 4;
    localparam logic [19:0] WIdle  = 20'h1C5BC;
    localparam logic [19:0] WIdleA = 20'h9C5BC;
    localparam logic [19:0] WSof   = 20'h150FB;
    localparam logic [19:0] WEof   = 20'h150FD;
    localparam logic [19:0] WEofT  = 20'h550FD;

    logic clk = 1'b0, rst = 1'b1, i_stop = 1'b0;
    logic [2:0] i_mode = 3'd0;
    logic o_stop_ack, o_tkmsb, o_tklsb, o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen;
    logic o_link_up, o_trunc;
    logic [15:0] o_txd;

    tlk2711_tx_sched_if s0_if ();
    tlk2711_tx_sched_if s1_if ();

    tlk2711_tx_sched #(.LOCK_CYCLES(L), .SYNC_WORDS(S), .IFG_WORDS(4), .MAX_WORDS(4)) dut (
        .clk(clk), .rst(rst), .i_mode(i_mode), .i_stop(i_stop), .o_stop_ack(o_stop_ack),
        .s0(s0_if), .s1(s1_if), .o_txd(o_txd), .o_tkmsb(o_tkmsb), .o_tklsb(o_tklsb),
        .o_enable(o_enable), .o_lckrefn(o_lckrefn), .o_loopen(o_loopen), .o_prbsen(o_prbsen),
        .o_testen(o_testen), .o_link_up(o_link_up), .o_trunc(o_trunc)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0, acc0 = 0, acc1 = 0;
    logic [17:0] q0[$], q1[$];       // {bubble, last, data}
    logic [19:0] wire_log[$];        // {stop_ack, trunc, tkmsb, tklsb, txd}
    logic [19:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1 wire_log.push_back({o_stop_ack, o_trunc, o_tkmsb, o_tklsb, o_txd});
    end

    initial begin
        s0_if.valid = 1'b0; s0_if.data = '0; s0_if.last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || q0.size() == 0) s0_if.valid = 1'b0;
            else begin
                s0_if.valid = !q0[0][17]; s0_if.last = q0[0][16]; s0_if.data = q0[0][15:0];
                #4;
                if (q0[0][17]) void'(q0.pop_front());
                else if (s0_if.ready) begin void'(q0.pop_front()); acc0++; end
            end
        end
    end

    initial begin
        s1_if.valid = 1'b0; s1_if.data = '0; s1_if.last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst || q1.size() == 0) s1_if.valid = 1'b0;
            else begin
                s1_if.valid = !q1[0][17]; s1_if.last = q1[0][16]; s1_if.data = q1[0][15:0];
                #4;
                if (q1[0][17]) void'(q1.pop_front());
                else if (s1_if.ready) begin void'(q1.pop_front()); acc1++; end
            end
        end
    end

    task automatic push(input int ch, input logic bubble, input logic last, input logic [15:0] d);
        if (ch == 0) q0.push_back({bubble, last, d});
        else         q1.push_back({bubble, last, d});
    endtask

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic [19:0] w, input int n);
        repeat (n) exp_q.push_back(w);
    endtask

    function automatic int find_sof(input int from);
        for (int i = from; i < wire_log.size(); i++)
            if (wire_log[i][17:0] == WSof[17:0]) return i;
        return -1;
    endfunction

    task automatic cmp_log(input string tag, input int start);
        check({tag, "_sof"}, start >= 0, 1);
        if (start >= 0)
            for (int i = 0; i < exp_q.size(); i++)
                check($sformatf("%s[%0d]", tag, i),
                      (start + i < wire_log.size()) ? wire_log[start + i] : 20'hxxxxx, exp_q[i]);
        exp_q.delete();
    endtask

    task automatic reset_hold();
        @(negedge clk);
        rst = 1'b1;
        q0.delete(); q1.delete();
        repeat (2) @(posedge clk);
    endtask

    task automatic reset_release();
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            if (o_link_up) break;
        end
        check("link_up", o_link_up, 1);
    endtask

    task automatic wait_ready0();
        for (int i = 0; i < 50; i++) begin
            @(posedge clk); #1;
            if (s0_if.ready) break;
        end
        check("ready_seen", s0_if.ready, 1);
    endtask

    int idx, m, nonidle, nf, a0;

    initial begin
        // Reset values and power-up sequence
        run(3);
        check("rst_txd", {o_tkmsb, o_tklsb, o_txd}, {2'b01, 16'hC5BC});
        check("rst_pins", {o_enable, o_lckrefn, o_loopen, o_prbsen, o_testen}, 5'b0);
        check("rst_status", {o_link_up, o_stop_ack, o_trunc, s0_if.ready, s1_if.ready}, 5'b0);
        @(negedge clk);
        rst = 1'b0;
        nonidle = 0;
        for (int k = 1; k <= L + S + 2; k++) begin
            @(posedge clk); #1;
            if ({o_tkmsb, o_tklsb, o_txd} != WIdle[17:0]) nonidle++;
            if (k == 1) check("en_c1", {o_enable, o_lckrefn}, 2'b10);
            if (k == 2) check("lck_c2", o_lckrefn, 1);
            if (k == L + S + 1) check("link_early", o_link_up, 0);
            if (k == L + S + 2) check("link_on", o_link_up, 1);
        end
        check("sync_idle", nonidle, 0);

        // Single frame on ch0
        m = wire_log.size();
        push(0, 0, 0, 16'h1111); push(0, 0, 0, 16'h2222); push(0, 0, 1, 16'h3333);
        run(25);
        ex(WSof, 1); ex(20'h00000, 1); ex(20'h01111, 1); ex(20'h02222, 1); ex(20'h03333, 1);
        ex(WEof, 1); ex(WIdle, 5);
        cmp_log("single", find_sof(m));
        check("single_acc", acc0, 3);

        // Contention from reset: ch0, ch1, ch0
        reset_hold();
        push(0, 0, 0, 16'hA001); push(0, 0, 1, 16'hA002); push(0, 0, 1, 16'hA003);
        push(1, 0, 0, 16'hB001); push(1, 0, 1, 16'hB002);
        m = wire_log.size();
        reset_release();
        run(40);
        ex(WSof, 1); ex(20'h00000, 1); ex(20'h0A001, 1); ex(20'h0A002, 1); ex(WEof, 1);
        ex(WIdle, 5);
        ex(WSof, 1); ex(20'h00001, 1); ex(20'h0B001, 1); ex(20'h0B002, 1); ex(WEof, 1);
        ex(WIdle, 5);
        ex(WSof, 1); ex(20'h00100, 1); ex(20'h0A003, 1); ex(WEof, 1);
        cmp_log("contend", find_sof(m));

        // Valid gaps on ch1 insert FILL words
        a0 = acc1;
        m = wire_log.size();
        push(1, 0, 0, 16'hC001); push(1, 1, 0, 16'h0); push(1, 1, 0, 16'h0);
        push(1, 0, 0, 16'hC002); push(1, 0, 1, 16'hC003);
        run(25);
        ex(WSof, 1); ex(20'h00101, 1); ex(20'h0C001, 1); ex(WIdle, 2); ex(20'h0C002, 1);
        ex(20'h0C003, 1); ex(WEof, 1);
        cmp_log("gaps", find_sof(m));
        check("gaps_acc", acc1 - a0, 3);

        // Truncation at 4 words, drain, then a normal frame
        reset_hold();
        reset_release();
        a0 = acc0;
        m = wire_log.size();
        for (int i = 1; i <= 6; i++) push(0, 0, i == 6, 16'hD000 + 16'(i));
        push(0, 0, 1, 16'hE001);
        run(40);
        ex(WSof, 1); ex(20'h00000, 1);
        for (int i = 1; i <= 4; i++) ex({4'b0, 16'hD000 + 16'(i)}, 1);
        ex(WEofT, 1); ex(WIdle, 7);
        ex(WSof, 1); ex(20'h00100, 1); ex(20'h0E001, 1); ex(WEof, 1);
        cmp_log("trunc", find_sof(m));
        check("trunc_acc", acc0 - a0, 7);

        // Sequence number wraps after 256 frames
        reset_hold();
        reset_release();
        m = wire_log.size();
        for (int i = 0; i < 257; i++) push(0, 0, 1, 16'(i));
        run(257 * 9 + 30);
        idx = m;
        nf = 0;
        for (int f = 0; f < 257; f++) begin
            idx = find_sof(idx);
            if (idx < 0) break;
            nf++;
            if (f == 255) check("hdr_ff", wire_log[idx + 1], 20'h0FF00);
            if (f == 256) check("hdr_wrap", wire_log[idx + 1], 20'h00000);
            idx++;
        end
        check("wrap_frames", nf, 257);

        // Stop raised mid-frame: frame completes, then stopped
        m = wire_log.size();
        push(0, 0, 0, 16'hF001); push(0, 0, 0, 16'hF002); push(0, 0, 1, 16'hF003);
        wait_ready0();
        @(negedge clk);
        i_stop = 1'b1;
        run(20);
        ex(WSof, 1); ex(20'h00100, 1); ex(20'h0F001, 1); ex(20'h0F002, 1); ex(20'h0F003, 1);
        ex(WEof, 1); ex(WIdle, 4); ex(WIdleA, 2);
        cmp_log("stop", find_sof(m));
        push(0, 0, 1, 16'h6001);
        m = wire_log.size();
        run(10);
        check("stop_nosof", find_sof(m) < 0, 1);
        check("stop_ack", o_stop_ack, 1);
        @(negedge clk);
        i_stop = 1'b0;
        m = wire_log.size();
        run(15);
        idx = find_sof(m);
        check("resume_sof", idx >= 0, 1);
        if (idx >= 0) check("resume_hdr", wire_log[idx + 1], 20'h00200);
        check("stop_ack_off", o_stop_ack, 0);

        // PRBS mode blocks grants; loopback mode does not
        @(negedge clk);
        i_mode = 3'd2;
        run(3);
        check("prbs_pins", {o_prbsen, o_loopen}, 2'b10);
        push(0, 0, 1, 16'h7001);
        m = wire_log.size();
        run(12);
        check("prbs_nosof", find_sof(m) < 0, 1);
        @(negedge clk);
        i_mode = 3'd1;
        run(15);
        check("loop_pins", {o_prbsen, o_loopen}, 2'b01);
        idx = find_sof(m);
        check("loop_sof", idx >= 0, 1);
        if (idx >= 0) check("loop_hdr", wire_log[idx + 1], 20'h00300);
        @(negedge clk);
        i_mode = 3'd0;
        run(2);

        // Reset mid-frame clears everything, including seq
        for (int i = 1; i <= 4; i++) push(0, 0, i == 4, 16'h8000 + 16'(i));
        wait_ready0();
        @(negedge clk);
        rst = 1'b1;
        q0.delete(); q1.delete();
        @(posedge clk); #1;
        check("mrst_txd", {o_tkmsb, o_tklsb, o_txd}, {2'b01, 16'hC5BC});
        check("mrst_pins", {o_enable, o_lckrefn, o_link_up, s0_if.ready}, 4'b0);
        reset_release();
        m = wire_log.size();
        push(0, 0, 1, 16'h9001);
        run(15);
        idx = find_sof(m);
        check("mrst_sof", idx >= 0, 1);
        if (idx >= 0) check("mrst_hdr", wire_log[idx + 1], 20'h00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/tlk2711_tx_sched.md
Name: tlk2711_tx_sched

Overview:
Transmit scheduler for one TLK2711 serializer lane. Runs the TLK2711 power-up sequence (enable, lock-ref, sync idles), then round-robin arbitrates two 16-bit stream requesters at frame boundaries. Each granted frame is wrapped as SOF / header / payload / EOF with K-character control on tkmsb/tklsb. It sits between user data sources in the clk_80 domain and the tlk2711 pins, and replaces a direct VIO-driven pattern source.

Parameters:
LOCK_CYCLES, 1024, cycles with lckrefn=1 before sync idles start
SYNC_WORDS, 64, idle words sent before first grant
IFG_WORDS, 4, minimum idle words between frames (>=1)
MAX_WORDS, 1024, maximum payload words per frame before forced EOF

Ports:
clk  in  1  TX word clock (clk_80); also drives gtx_clk externally
rst  in  1  synchronous active-high reset
i_mode  in  3  0=normal, 1=serial loopback, 2=PRBS test; others=normal
i_stop  in  1  level; finish current frame, then hold idle
o_stop_ack  out  1  high while stopped
s0_valid/s1_valid  in  1  source word valid
s0_data/s1_data  in  16  source word
s0_last/s1_last  in  1  last payload word of frame
s0_ready/s1_ready  out  1  word accepted when valid&ready
o_txd  out  16  TLK2711 TXD
o_tkmsb  out  1  TXD[15:8] is K-char
o_tklsb  out  1  TXD[7:0] is K-char
o_enable  out  1  device enable
o_lckrefn  out  1  lock-to-reference (active-low pin, 1=track data)
o_loopen  out  1  loopback enable
o_prbsen  out  1  PRBS enable
o_testen  out  1  test enable, tied 0
o_link_up  out  1  high from end of SYNC onward
o_trunc  out  1  one-cycle pulse on forced EOF

Behaviour:
- Words: IDLE={8'hC5,8'hBC} tklsb=1 tkmsb=0; SOF={8'h50,8'hFB} tklsb=1; EOF={8'h50,8'hFD} tklsb=1; HDR={seq[7:0],7'b0,ch} with no K; payload has no K. FILL=IDLE.
- All pin outputs are registered. The word for a state appears on o_txd one cycle after the state/handshake.
- Reset values: o_txd=IDLE, tklsb=1, tkmsb=0, enable=0, lckrefn=0, loopen=0, prbsen=0, testen=0, ready=0, link_up=0, stop_ack=0, trunc=0, seq0=seq1=0, rr pointer=ch0.
- States:
  - PWR: enable=1 after 1 cycle, go to LOCK.
  - LOCK: lckrefn=1; counts LOCK_CYCLES, then SYNC.
  - SYNC: emit SYNC_WORDS IDLEs, then set link_up and go to IDLE.
  - IDLE: emit IDLE. If i_stop, go to STOPPED. Otherwise, if any sN_valid, grant and go to SOF.
  - SOF, then HDR (one word each).
  - DATA: ready=1 for the granted channel only. Each handshake emits the payload word. A cycle with valid=0 emits FILL and stays in DATA. last, or the word count reaching MAX_WORDS, goes to EOF.
  - EOF: emits EOF, increments seq for the granted channel (8-bit wrap 255->0), flips the rr pointer to the other channel, then GAP.
  - GAP: emit IFG_WORDS IDLEs, then IDLE.
  - DRAIN (after a forced EOF only): ready=1 for that channel, discards words until last is accepted, then IDLE. Pending grants wait.
  - STOPPED: emit IDLE, stop_ack=1. Leave to IDLE when i_stop=0.
- Arbitration: round robin. If both channels are valid in IDLE, the rr-pointer channel wins. A single requester always wins. The grant is fixed until EOF.
- Truncation: the MAX_WORDS-th word is accepted without last, then EOF, o_trunc=1 for one cycle, then GAP then DRAIN.
- i_stop asserted in SOF/HDR/DATA has no effect until IDLE. It is never sampled mid-frame.
- i_mode is sampled only in IDLE/STOPPED and drives loopen/prbsen. While prbsen=1, no grants are issued and IDLE words are sent.
- rst mid-frame: immediate return to reset values. No EOF is sent and seq is cleared.

Test Plan:
- Startup: release rst -> enable=1 at cycle 1, lckrefn=1 at 2, first link_up at 2+LOCK_CYCLES+SYNC_WORDS (+1 register). o_txd=16'hC5BC/tklsb=1 throughout.
- Single frame: s0 sends 3 words 0x1111,0x2222,0x3333(last) -> wire SOF, 16'h0000, 0x1111, 0x2222, 0x3333, EOF, then 4 IDLEs. seq0=1.
- Contention: s0 and s1 valid together from reset -> ch0 frame, then ch1 frame (HDR 16'h0001), then ch0 again. No frame starts earlier than 4 IDLEs after the previous EOF.
- Valid gaps: s1 drops valid for 2 cycles mid-frame -> two FILL words inserted, no extra ready.
- Truncation with MAX_WORDS=4: source sends 6 words -> 4 payload words, EOF, trunc pulse, 2 words drained with no wire output, next frame normal. 256 frames on ch0 -> HDR seq wraps to 0x00.
- i_stop raised during DATA -> frame completes with EOF, GAP, then stop_ack=1. rst in DATA -> next cycle o_txd=IDLE, enable=0, seq cleared.
